// File: rtl/baud_pkg.sv
// Shared constants, types and reset-divisor helper for the UART baud-tick generator.
package baud_pkg;

    localparam int FRAC_W    = 4;
    localparam int DIV_W_DEF = 16;

    typedef logic [DIV_W_DEF-1:0] baud_div_t;

    // Clock cycles per oversample tick, truncated; 0 for nonsensical arguments.
    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        if (baud <= 0 || os <= 0) begin
            return 0;
        end
        return clk_freq / (baud * os);
    endfunction

endpackage

// File: rtl/baud_prescaler.sv
// Divisor counter with shadowed divisor update; emits the oversample tick.
// Optional BAUD_FRAC_EN adds a fractional-divisor accumulator (div_frac port).
module baud_prescaler
    import baud_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int RST_DIV = 26
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              en,
    input  logic              div_wr,
    input  logic [DIV_W-1:0]  div_in,
`ifdef BAUD_FRAC_EN
    input  logic [FRAC_W-1:0] div_frac,
`endif
    input  logic              sync,
    output logic              os_stb,
    output logic              halted,
    output logic              os_tick,
    output logic [DIV_W-1:0]  div_cur
);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_pend;
    logic [DIV_W-1:0] div_next;
    logic [DIV_W-1:0] period_end;
    logic             pend;
    logic             tc;
    logic             apply;

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] frac_q;
    logic [FRAC_W-1:0] frac_pend;
    logic [FRAC_W-1:0] frac_next;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   acc_sum;
    logic              extra;
`endif

    always_comb begin
        halted     = (div_q == '0);
        period_end = div_q - DIV_W'(1);
`ifdef BAUD_FRAC_EN
        // A carry from the accumulator stretches this one period by a cycle.
        if (extra) begin
            period_end = div_q;
        end
        frac_next = div_wr ? div_frac : frac_pend;
        acc_sum   = {1'b0, acc} + {1'b0, frac_q};
`endif
        // >= keeps a divisor shrunk while paused from running past its end.
        tc       = en && !halted && (div_cnt >= period_end);
        os_stb   = tc && !sync;
        apply    = pend && (sync || tc || !en || halted);
        div_next = div_wr ? div_in : div_pend;
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            div_cnt <= '0;
            div_q   <= DIV_W'(RST_DIV);
            pend    <= 1'b0;
            os_tick <= 1'b0;
        end else begin
            os_tick <= os_stb;

            if (sync || tc || halted) begin
                div_cnt <= '0;
            end else if (en) begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            // A write coinciding with the apply edge wins over the older pending value.
            if (apply) begin
                div_q <= div_next;
                pend  <= 1'b0;
            end else if (div_wr) begin
                pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (div_wr) begin
            div_pend  <= div_in;
`ifdef BAUD_FRAC_EN
            frac_pend <= div_frac;
`endif
        end
    end

`ifdef BAUD_FRAC_EN
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            frac_q <= '0;
            acc    <= '0;
            extra  <= 1'b0;
        end else begin
            if (apply) begin
                frac_q <= frac_next;
            end
            if (sync) begin
                acc   <= '0;
                extra <= 1'b0;
            end else if (tc) begin
                acc   <= acc_sum[FRAC_W-1:0];
                extra <= acc_sum[FRAC_W];
            end
        end
    end
`endif

    assign div_cur = div_q;

endmodule

// File: rtl/baud_tick_gen.sv
// Programmable UART baud-tick generator: oversample tick, bit tick and bit phase.
// Define BAUD_FRAC_EN to add the div_frac input for fractional divisors.
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD_RATE  = 2400,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = DIV_W_DEF,
    parameter int RST_DIV    = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE)
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic                          en,
    input  logic                          div_wr,
    input  logic [DIV_W-1:0]              div_in,
`ifdef BAUD_FRAC_EN
    input  logic [FRAC_W-1:0]             div_frac,
`endif
    input  logic                          sync,
    output logic                          os_tick,
    output logic                          bit_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] bit_phase,
    output logic [DIV_W-1:0]              div_cur
);

    localparam int              PH_W    = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] OS_LAST = PH_W'(OVERSAMPLE - 1);

    logic            os_stb;
    logic            halted;
    logic [PH_W-1:0] os_cnt;

    baud_prescaler #(
        .DIV_W   (DIV_W),
        .RST_DIV (RST_DIV)
    ) u_prescaler (
        .clk      (clk),
        .srst     (srst),
        .en       (en),
        .div_wr   (div_wr),
        .div_in   (div_in),
`ifdef BAUD_FRAC_EN
        .div_frac (div_frac),
`endif
        .sync     (sync),
        .os_stb   (os_stb),
        .halted   (halted),
        .os_tick  (os_tick),
        .div_cur  (div_cur)
    );

    // os_cnt moves on the same edge that raises os_tick, so bit_phase lines up with it.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            os_cnt   <= '0;
            bit_tick <= 1'b0;
        end else if (sync || halted) begin
            os_cnt   <= '0;
            bit_tick <= 1'b0;
        end else begin
            bit_tick <= os_stb && (os_cnt == OS_LAST);
            if (os_stb) begin
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + PH_W'(1);
            end
        end
    end

    assign bit_phase = os_cnt;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Scoreboard bench for baud_tick_gen: expected ticks queued by stimulus, checked by a monitor.
module tb_baud_tick_gen;

    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             srst;
    logic             en;
    logic             div_wr;
    logic [DIV_W-1:0] div_in;
`ifdef BAUD_FRAC_EN
    logic [3:0]       div_frac;
`endif
    logic             sync;
    logic             os_tick;
    logic             bit_tick;
    logic [3:0]       bit_phase;
    logic [DIV_W-1:0] div_cur;

    typedef struct {
        int cyc;
        int ph;
        int bt;
        int dv;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   base     = 0;
    int   exp_ph   = 0;
    int   last_cyc = 0;
    int   n_vec    = 0;
    int   n_bad    = 0;
    int   t_f;
    int   acc_f;
    int   ext_f;
    int   t_r;

    baud_tick_gen #(
        .CLK_FREQ   (1000000),
        .BAUD_RATE  (2400),
        .OVERSAMPLE (16),
        .DIV_W      (DIV_W)
    ) dut (
        .clk       (clk),
        .srst      (srst),
        .en        (en),
        .div_wr    (div_wr),
        .div_in    (div_in),
`ifdef BAUD_FRAC_EN
        .div_frac  (div_frac),
`endif
        .sync      (sync),
        .os_tick   (os_tick),
        .bit_tick  (bit_tick),
        .bit_phase (bit_phase),
        .div_cur   (div_cur)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected os_tick at absolute cycle c; phase follows a 16-way wrap, bit_tick on the wrap.
    task automatic push(input int c, input int dv);
        exp_t e;
        exp_ph = (exp_ph + 1) % 16;
        e.cyc  = c;
        e.ph   = exp_ph;
        e.bt   = (exp_ph == 0) ? 1 : 0;
        e.dv   = dv;
        q.push_back(e);
        last_cyc = c;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (srst !== 1'b1) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                n_vec++;
                n_bad++;
                $display("FAIL missing_tick: no os_tick at cycle %0d, required phase %0d div %0d",
                         q[0].cyc, q[0].ph, q[0].dv);
                q.delete(0);
            end
            if (os_tick === 1'b1) begin
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    mon_e = q.pop_front();
                    n_vec++;
                    if (bit_tick !== (mon_e.bt != 0) || bit_phase !== 4'(mon_e.ph) ||
                        div_cur !== 16'(mon_e.dv)) begin
                        n_bad++;
                        $display("FAIL tick@%0d: bit_tick/phase/div got %0b/%0d/%0d, required %0d/%0d/%0d",
                                 cyc, bit_tick, bit_phase, div_cur, mon_e.bt, mon_e.ph, mon_e.dv);
                    end
                end else begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_tick: os_tick=1 at cycle %0d, required 0", cyc);
                end
            end else if (bit_tick === 1'b1) begin
                n_vec++;
                n_bad++;
                $display("FAIL stray_bit_tick: bit_tick=1 without os_tick at cycle %0d, required 0", cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        srst   = 1'b1;
        en     = 1'b0;
        div_wr = 1'b0;
        div_in = '0;
        sync   = 1'b0;
`ifdef BAUD_FRAC_EN
        div_frac = '0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_os_tick", 32'(os_tick), 0);
        chk("rst_bit_tick", 32'(bit_tick), 0);
        chk("rst_bit_phase", 32'(bit_phase), 0);
        chk("rst_div_cur", 32'(div_cur), 26);

        // Default rate: 26-cycle periods, bit_tick on the 16th.
        srst = 1'b0;
        en   = 1'b1;
        base = cyc;
        for (int k = 1; k <= 17; k++) push(base + 26 * k, 26);

        // Two writes before apply; the later one (10) takes effect at the next tick.
        wait_to(base + 448); div_wr = 1'b1; div_in = 16'd7;
        wait_to(base + 449); div_in = 16'd10;
        wait_to(base + 450); div_wr = 1'b0;
        for (int k = 0; k < 20; k++) push(base + 468 + 10 * k, 10);

        // Pending 30 overwritten by a write on the apply edge itself.
        wait_to(base + 660); div_wr = 1'b1; div_in = 16'd30;
        wait_to(base + 661); div_wr = 1'b0;
        push(base + 668, 26);
        push(base + 694, 26);
        push(base + 720, 26);
        wait_to(base + 667); div_wr = 1'b1; div_in = 16'd26;
        wait_to(base + 668); div_wr = 1'b0;

        // sync mid-period, then sync on a terminal-count edge.
        wait_to(base + 732); sync = 1'b1;
        exp_ph = 0;
        push(base + 759, 26);
        wait_to(base + 733); sync = 1'b0;
        wait_to(base + 784); sync = 1'b1;
        exp_ph = 0;
        push(base + 811, 26);
        push(base + 837, 26);
        wait_to(base + 785); sync = 1'b0;

        // sync applies a pending divisor.
        wait_to(base + 840); div_wr = 1'b1; div_in = 16'd20;
        wait_to(base + 841); div_wr = 1'b0;
        wait_to(base + 845); sync = 1'b1;
        exp_ph = 0;
        push(base + 866, 20);
        push(base + 886, 20);
        wait_to(base + 846); sync = 1'b0;
        chk("sync_apply_div", 32'(div_cur), 20);

        // Divisor 0 halts after the current period; divisor 1 ticks every cycle.
        wait_to(base + 890); div_wr = 1'b1; div_in = 16'd0;
        wait_to(base + 891); div_wr = 1'b0;
        push(base + 906, 0);
        wait_to(base + 950);
        chk("halt_div_cur", 32'(div_cur), 0);
        chk("halt_bit_phase", 32'(bit_phase), 0);
        exp_ph = 0;
        for (int c = 963; c <= 996; c++) push(base + c, 1);
        push(base + 997, 26);
        push(base + 1023, 26);
        push(base + 1049, 26);
        wait_to(base + 960); div_wr = 1'b1; div_in = 16'd1;
        wait_to(base + 961); div_wr = 1'b0;
        wait_to(base + 995); div_wr = 1'b1; div_in = 16'd26;
        wait_to(base + 996); div_wr = 1'b0;

        // en low at div_cnt=5 for 40 cycles; divisor writes land at once while paused.
        wait_to(base + 1054); en = 1'b0;
        push(base + 1115, 26);
        push(base + 1141, 26);
        wait_to(base + 1060); div_wr = 1'b1; div_in = 16'd30;
        wait_to(base + 1061); div_wr = 1'b0;
        wait_to(base + 1063);
        chk("paused_apply_30", 32'(div_cur), 30);
        wait_to(base + 1070); div_wr = 1'b1; div_in = 16'd26;
        wait_to(base + 1071); div_wr = 1'b0;
        wait_to(base + 1075);
        chk("paused_apply_26", 32'(div_cur), 26);
        wait_to(base + 1080);
        chk("paused_bit_phase", 32'(bit_phase), 5);
        wait_to(base + 1094); en = 1'b1;

`ifdef BAUD_FRAC_EN
        // 26 + 1/16: each carry of the 4-bit accumulator stretches the following period.
        wait_to(base + 1150); div_wr = 1'b1; div_in = 16'd26; div_frac = 4'd1;
        wait_to(base + 1151); div_wr = 1'b0;
        wait_to(base + 1155); sync = 1'b1;
        exp_ph = 0;
        t_f    = base + 1156;
        acc_f  = 0;
        ext_f  = 0;
        for (int k = 0; k < 416; k++) begin
            t_f   = t_f + 26 + ext_f;
            push(t_f, 26);
            acc_f = acc_f + 1;
            ext_f = acc_f / 16;
            acc_f = acc_f % 16;
        end
        wait_to(base + 1156); sync = 1'b0;
`endif

        // Reset mid-period with a pending write: both phase and the write are discarded.
        t_r = last_cyc + 2;
        wait_to(t_r); div_wr = 1'b1; div_in = 16'd5;
        wait_to(t_r + 1); div_wr = 1'b0;
        wait_to(t_r + 3);
        #2 srst = 1'b1;
        #1;
        chk("midrst_os_tick", 32'(os_tick), 0);
        chk("midrst_bit_phase", 32'(bit_phase), 0);
        chk("midrst_div_cur", 32'(div_cur), 26);
        @(negedge clk);
        @(negedge clk);
        srst   = 1'b0;
        base   = cyc;
        exp_ph = 0;
        for (int k = 1; k <= 3; k++) push(base + 26 * k, 26);
        wait_to(base + 26 * 3 + 8);

        chk("queue_drained", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
